// File: rtl/ram_pkg.sv
// ram_pkg: shared types for the sweep-clearable single-port RAM.
package ram_pkg;
    typedef enum logic [1:0] {
        READ_FIRST,
        WRITE_FIRST,
        NO_CHANGE
    } rdw_mode_t;

    typedef enum logic {
        IDLE,
        CLEAR
    } clr_state_t;
endpackage

// File: rtl/ram_rd_pipe.sv
// ram_rd_pipe: read result pipeline OUT_REG stages deep; data holds between results.
module ram_rd_pipe #(
    parameter int WIDTH   = 32,
    parameter int OUT_REG = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);
    if (OUT_REG == 0) begin : g_comb
        logic [WIDTH-1:0] r_hold;
        always_ff @(posedge i_clk) begin
            if (i_rst) r_hold <= '0;
            else if (i_valid) r_hold <= i_data;
        end
        assign o_valid = i_valid;
        assign o_data  = i_valid ? i_data : r_hold;
    end else begin : g_reg
        logic [OUT_REG-1:0] r_v;
        logic [WIDTH-1:0]   r_d [OUT_REG];
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_v <= '0;
                for (int i = 0; i < OUT_REG; i++) r_d[i] <= '0;
            end else begin
                r_v[0] <= i_valid;
                if (i_valid) r_d[0] <= i_data;
                for (int i = 1; i < OUT_REG; i++) begin
                    r_v[i] <= r_v[i-1];
                    if (r_v[i-1]) r_d[i] <= r_d[i-1];
                end
            end
        end
        assign o_valid = r_v[OUT_REG-1];
        assign o_data  = r_d[OUT_REG-1];
    end
endmodule

// File: rtl/ram_sp_clr.sv
// ram_sp_clr: single-port byte-enabled RAM with a one-word-per-cycle clear sweep
// and configurable read latency and read-during-write behaviour.
module ram_sp_clr
    import ram_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter int               DEPTH      = 16,
    parameter int               BYTE_W     = 8,
    parameter int               OUT_REG    = 1,
    parameter rdw_mode_t        RDW_MODE   = READ_FIRST,
    parameter logic [WIDTH-1:0] CLR_VAL    = '0,
    parameter logic             CLR_ON_RST = 1'b1
) (
    input  logic                       rw_clk_i,
    input  logic                       rw_rst_i,
    input  logic                       clr_i,
    output logic                       busy_o,
    input  logic                       wr_en_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    input  logic [WIDTH/BYTE_W-1:0]    wr_byte_en_i,
    input  logic [$clog2(DEPTH)-1:0]   rw_addr_i,
    input  logic                       rd_en_i,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic                       rd_valid_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int NB = WIDTH / BYTE_W;

    if (WIDTH % BYTE_W != 0) begin : g_bad_lane
        $error("ram_sp_clr: WIDTH must be a multiple of BYTE_W");
    end
    if (OUT_REG < 0 || OUT_REG > 2) begin : g_bad_lat
        $error("ram_sp_clr: OUT_REG must be 0, 1 or 2");
    end

    clr_state_t       r_state;
    logic [AW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_busy, w_wr, w_rd, w_rd_ok;
    logic [WIDTH-1:0] w_old, w_merged, w_rd_data;

    assign w_busy = (r_state == CLEAR);
    assign busy_o = w_busy;
    assign w_wr   = wr_en_i && !w_busy;
    assign w_rd   = rd_en_i && !w_busy;
    assign w_old  = r_mem[rw_addr_i];

    for (genvar k = 0; k < NB; k++) begin : g_lane
        assign w_merged[k*BYTE_W +: BYTE_W] = wr_byte_en_i[k] ? wr_data_i[k*BYTE_W +: BYTE_W]
                                                              : w_old[k*BYTE_W +: BYTE_W];
    end

    // Read and write share one address, so any overlap is a read-during-write.
    assign w_rd_ok   = w_rd && !(RDW_MODE == NO_CHANGE && w_wr);
    assign w_rd_data = (RDW_MODE == WRITE_FIRST && w_wr) ? w_merged : w_old;

    always_ff @(posedge rw_clk_i) begin
        if (rw_rst_i) begin
            r_state <= CLR_ON_RST ? CLEAR : IDLE;
            r_cnt   <= '0;
        end else if (clr_i) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
        end else if (r_state == CLEAR) begin
            r_cnt <= r_cnt + AW'(1);
            if (r_cnt == AW'(DEPTH - 1)) begin
                r_state <= IDLE;
                r_cnt   <= '0;
            end
        end
    end

    always_ff @(posedge rw_clk_i) begin
        if (w_busy) r_mem[r_cnt] <= CLR_VAL;
        else if (w_wr) r_mem[rw_addr_i] <= w_merged;
    end

    ram_rd_pipe #(
        .WIDTH   (WIDTH),
        .OUT_REG (OUT_REG)
    ) u_rd_pipe (
        .i_clk   (rw_clk_i),
        .i_rst   (rw_rst_i),
        .i_valid (w_rd_ok),
        .i_data  (w_rd_data),
        .o_valid (rd_valid_o),
        .o_data  (rd_data_o)
    );
endmodule

// File: tb/tb_ram_sp_clr.sv
// tb_ram_sp_clr: three ram_sp_clr variants (latency 0/1/2, NO_CHANGE/READ_FIRST/WRITE_FIRST)
// on shared stimulus, checked against one memory model plus directed literal expectations.
module tb_ram_sp_clr;
    import ram_pkg::*;

    localparam logic [31:0] CV = 32'hA5A5A5A5;

    logic        clk = 1'b0, rst = 1'b1, clr = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic [3:0]  be = '0;
    logic [3:0]  addr = '0;
    logic        busy0, busy1, busy2, v0, v1, v2;
    logic [31:0] d0, d1, d2;
    int          n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    ram_sp_clr #(.WIDTH(32), .DEPTH(16), .BYTE_W(8), .OUT_REG(0), .RDW_MODE(NO_CHANGE),
                 .CLR_VAL(CV), .CLR_ON_RST(1'b1)) dut0 (
        .rw_clk_i(clk), .rw_rst_i(rst), .clr_i(clr), .busy_o(busy0), .wr_en_i(wr_en),
        .wr_data_i(wr_data), .wr_byte_en_i(be), .rw_addr_i(addr), .rd_en_i(rd_en),
        .rd_data_o(d0), .rd_valid_o(v0));
    ram_sp_clr #(.WIDTH(32), .DEPTH(16), .BYTE_W(8), .OUT_REG(1), .RDW_MODE(READ_FIRST),
                 .CLR_VAL(CV), .CLR_ON_RST(1'b1)) dut1 (
        .rw_clk_i(clk), .rw_rst_i(rst), .clr_i(clr), .busy_o(busy1), .wr_en_i(wr_en),
        .wr_data_i(wr_data), .wr_byte_en_i(be), .rw_addr_i(addr), .rd_en_i(rd_en),
        .rd_data_o(d1), .rd_valid_o(v1));
    ram_sp_clr #(.WIDTH(32), .DEPTH(16), .BYTE_W(8), .OUT_REG(2), .RDW_MODE(WRITE_FIRST),
                 .CLR_VAL(CV), .CLR_ON_RST(1'b1)) dut2 (
        .rw_clk_i(clk), .rw_rst_i(rst), .clr_i(clr), .busy_o(busy2), .wr_en_i(wr_en),
        .wr_data_i(wr_data), .wr_byte_en_i(be), .rw_addr_i(addr), .rd_en_i(rd_en),
        .rd_data_o(d2), .rd_valid_o(v2));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] b);
        for (int k = 0; k < 4; k++) if (b[k]) o[k*8 +: 8] = n[k*8 +: 8];
        return o;
    endfunction

    // Model: memory array, remaining sweep words, and expected outputs per latency.
    logic [31:0] mem [16];
    int          rem = 0;
    bit          on = 0;
    logic        e1_v = 0, e2_v = 0, s2_v = 0;
    logic [31:0] e1_d = '0, e2_d = '0, s2_d = '0, h0 = '0;

    always @(posedge clk) begin : model
        logic [31:0] old, mrg;
        logic ra, wa, bz;
        if (rst) begin
            on = 1; rem = 16;
            e1_v = 0; e1_d = '0; s2_v = 0; s2_d = '0; e2_v = 0; e2_d = '0; h0 = '0;
        end else begin
            bz  = rem > 0;
            ra  = rd_en && !bz;
            wa  = wr_en && !bz;
            old = mem[addr];
            mrg = merge(old, wr_data, be);
            if (ra && !wa) h0 = old;
            e2_v = s2_v;
            if (s2_v) e2_d = s2_d;
            s2_v = ra;
            s2_d = wa ? mrg : old;
            e1_v = ra;
            if (ra) e1_d = old;
            if (bz) begin
                mem[16 - rem] = CV;
                rem--;
            end else if (wa) mem[addr] = mrg;
            if (clr) rem = 16;
        end
    end

    always @(negedge clk) begin : compare
        logic bz, ev0;
        if (on) begin
            bz  = rem > 0;
            ev0 = rd_en && !bz && !wr_en;
            chk("busy0", 32'(busy0), 32'(bz));
            chk("busy1", 32'(busy1), 32'(bz));
            chk("busy2", 32'(busy2), 32'(bz));
            chk("valid0", 32'(v0), 32'(ev0));
            chk("data0", d0, ev0 ? mem[addr] : h0);
            chk("valid1", 32'(v1), 32'(e1_v));
            chk("data1", d1, e1_d);
            chk("valid2", 32'(v2), 32'(e2_v));
            chk("data2", d2, e2_d);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        repeat (2) cyc();
        rst = 0;
        n = 0;
        while (busy1 && n < 64) begin cyc(); n++; end
        chk("rst_sweep_len", n, 16);
        for (int a = 0; a < 16; a++) begin
            rd_en = 1; addr = 4'(a);
            cyc();
            chk("swept_valid", 32'(v1), 1);
            chk("swept_data", d1, CV);
        end
        rd_en = 0;

        wr_en = 1; addr = 4'd3; wr_data = 32'h11223344; be = 4'b0101;
        cyc();
        wr_en = 0; rd_en = 1;
        cyc();
        rd_en = 0;
        chk("byte_en_merge", d1, 32'hA522A544);

        wr_en = 1; rd_en = 1; addr = 4'd5; wr_data = 32'hDEADBEEF; be = 4'hF;
        #1;
        chk("nc_valid", 32'(v0), 0);
        chk("nc_hold", d0, 32'hA522A544);
        cyc();
        wr_en = 0; rd_en = 0;
        chk("rf_valid", 32'(v1), 1);
        chk("rf_data", d1, CV);
        cyc();
        chk("wf_valid", 32'(v2), 1);
        chk("wf_data", d2, 32'hDEADBEEF);

        clr = 1; rd_en = 1; addr = 4'd3;
        cyc();
        clr = 0; rd_en = 0;
        chk("rd_before_busy_v", 32'(v1), 1);
        chk("rd_before_busy_d", d1, 32'hA522A544);
        n = 0;
        for (int k = 0; k < 64; k++) begin
            if (!busy1) break;
            clr = (k == 4); wr_en = 1; rd_en = 1; addr = 4'd0; wr_data = 32'(k); be = 4'hF;
            cyc();
            n++;
        end
        clr = 0; wr_en = 0; rd_en = 0;
        chk("double_clr_len", n, 21);
        rd_en = 1; addr = 4'd0;
        cyc();
        chk("busy_write_ignored", d1, CV);
        addr = 4'd3;
        cyc();
        rd_en = 0;
        chk("clr_overwrote", d1, CV);

        clr = 1;
        cyc();
        clr = 0;
        repeat (9) cyc();
        rst = 1;
        cyc();
        rst = 0;
        n = 0;
        while (busy1 && n < 64) begin cyc(); n++; end
        chk("rst_mid_sweep_len", n, 16);

        for (int a = 0; a < 16; a++) begin
            wr_en = 1; addr = 4'(a); be = 4'hF; wr_data = 32'h01010101 * (a + 1);
            cyc();
        end
        wr_en = 0;
        n = 0;
        for (int i = 0; i < 18; i++) begin
            rd_en = (i < 16); addr = 4'(i);
            cyc();
            if (v2) n++;
            if (i == 0) chk("burst_first_latency", 32'(v2), 0);
            else if (i <= 16) begin
                chk("burst_valid", 32'(v2), 1);
                chk("burst_data", d2, 32'h01010101 * i);
            end
        end
        rd_en = 0;
        chk("burst_count", n, 16);
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ram_sp_clr.md
RAM_SP_CLR -- requirements
Module: ram_sp_clr

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width in bits.
REQ-002 SHALL have parameter DEPTH, default 16: number of words; address width is $clog2(DEPTH).
REQ-003 SHALL have parameter BYTE_W, default 8: byte-lane width; WIDTH % BYTE_W == 0 is an elaboration error otherwise.
REQ-004 SHALL have parameter OUT_REG, default 1: read latency in cycles; legal values 0, 1, 2.
REQ-005 SHALL have parameter RDW_MODE, default READ_FIRST: read-during-write mode; legal values READ_FIRST, WRITE_FIRST, NO_CHANGE.
REQ-006 SHALL have parameter CLR_VAL, default '0: word value written by a clear sweep.
REQ-007 SHALL have parameter CLR_ON_RST, default 1: when 1, every reset starts a clear sweep.
REQ-008 rw_clk_i  in  1  sole clock; all logic on its rising edge.
REQ-009 rw_rst_i  in  1  reset, synchronous, active-high.
REQ-010 clr_i  in  1  one-cycle request to clear the whole array.
REQ-011 busy_o  out  1  clear sweep in progress; user accesses are ignored.
REQ-012 wr_en_i  in  1  write strobe.
REQ-013 wr_data_i  in  WIDTH  write data.
REQ-014 wr_byte_en_i  in  WIDTH/BYTE_W  per-lane write enable.
REQ-015 rw_addr_i  in  $clog2(DEPTH)  shared read/write address.
REQ-016 rd_en_i  in  1  read strobe.
REQ-017 rd_data_o  out  WIDTH  read data.
REQ-018 rd_valid_o  out  1  rd_data_o carries the result of an accepted read.

Function
REQ-019 FSM states: IDLE and CLEAR; IDLE -> CLEAR on clr_i, or on reset when CLR_ON_RST=1; CLEAR -> IDLE after the write to address DEPTH-1.
REQ-020 In CLEAR, a counter starting at 0 SHALL write CLR_VAL to one address per cycle, so a sweep takes exactly DEPTH cycles; busy_o=1 throughout.
REQ-021 clr_i asserted in CLEAR SHALL restart the counter at 0; the sweep still ends after DEPTH further cycles.
REQ-022 While busy_o=1, wr_en_i and rd_en_i SHALL be ignored: no array write, no rd_valid_o.
REQ-023 A write is accepted when wr_en_i=1 and busy_o=0; only lanes with wr_byte_en_i[k]=1 SHALL update, and the other lanes keep their contents.
REQ-024 A read is accepted when rd_en_i=1 and busy_o=0; rd_valid_o SHALL assert exactly OUT_REG cycles after acceptance, for one cycle per read. With OUT_REG=0 it is combinational in the same cycle.
REQ-025 With OUT_REG=2, back-to-back reads SHALL sustain one result per cycle.
REQ-026 rd_data_o SHALL hold its last value while no new result is produced.
REQ-027 A read and a write accepted in the same cycle at the same address SHALL behave as follows.
  - READ_FIRST: the read returns the old word.
  - WRITE_FIRST: the read returns the merged word, with new data in enabled lanes and old data in the others.
  - NO_CHANGE: the read is suppressed; no rd_valid_o is produced and rd_data_o is unchanged.
REQ-028 A read and a write at different addresses in the same cycle SHALL both complete normally.
REQ-029 A read accepted one cycle before busy_o rises SHALL still produce its result.

Reset
REQ-030 On rw_rst_i=1, the following SHALL take these values at the next edge.
  - rd_data_o = '0 and rd_valid_o = 0.
  - All read pipeline stages are cleared.
  - Counter = 0.
  - State = CLEAR if CLR_ON_RST=1, else IDLE; busy_o follows the state.
REQ-031 A reset during a sweep SHALL restart the sweep from address 0.
REQ-032 Array contents SHALL NOT be reset except by the sweep.

Structure
REQ-033 Package ram_pkg SHALL hold the rdw_mode_t enum (READ_FIRST, WRITE_FIRST, NO_CHANGE) and the clr_state_t enum (IDLE, CLEAR).
REQ-034 The read-data/valid pipeline SHALL be the sub-module ram_rd_pipe, parameterised by WIDTH and OUT_REG.

Verification (WIDTH=32, DEPTH=16, BYTE_W=8, OUT_REG=1, CLR_VAL=32'hA5A5A5A5, CLR_ON_RST=1)
REQ-035 Release reset -> busy_o=1 for exactly 16 cycles; then a read of each address returns 32'hA5A5A5A5 one cycle later with rd_valid_o=1.
REQ-036 Write 32'h11223344 to address 3 with byte enable 4'b0101 -> a read of address 3 returns 32'hA522A544.
REQ-037 Write 32'hDEADBEEF to address 5 with byte enable 4'hF while simultaneously reading address 5 -> the result depends on RDW_MODE.
  - READ_FIRST: 32'hA5A5A5A5.
  - WRITE_FIRST: 32'hDEADBEEF.
  - NO_CHANGE: rd_valid_o=0.
REQ-038 Pulse clr_i, then pulse it again 5 cycles later -> busy_o=1 for 21 cycles total; reads and writes issued meanwhile have no effect and produce no valid.
REQ-039 Assert rw_rst_i at sweep address 9 -> the sweep restarts at 0 and busy_o stays high for 16 cycles after reset release.
REQ-040 With OUT_REG=2, read addresses 0..15 back-to-back -> 16 consecutive rd_valid_o pulses, the first one 2 cycles after the first read.
